wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin arbiter that lets several pipelined Wishbone masters share one Wishbone master port. It sits between the bus masters (CPU fetch, CPU data, DMA/test masters) and the `wb_multiplexer` address decoder. The winner owns the bus for its whole `cyc` period. Losers see `stall` held high until they are granted.

## Interface
Parameters:
- `Count`, 2: number of requesting masters (≥2).
- `DataWidth`, 32: data width.
- `AddrWidth`, 32: address width.
- `TimeoutCycles`, 255: watchdog limit, used only with the timeout feature.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `m_cyc`, `m_stb`, `m_we`, in, [Count]: per-master request controls.
- `m_addr`, in, [Count][AddrWidth]: per-master address.
- `m_data_m`, in, [Count][DataWidth]: per-master write data.
- `m_sel`, in, [Count][DataWidth/8]: per-master byte selects.
- `m_data_s`, out, [Count][DataWidth]: read data to each master.
- `m_ack`, `m_stall`, `m_err`, out, [Count]: per-master responses.
- `s_cyc`, `s_stb`, `s_we`, out, 1: controls to the shared bus.
- `s_addr`, out, AddrWidth: address to the shared bus.
- `s_data_m`, out, DataWidth: write data to the shared bus.
- `s_sel`, out, DataWidth/8: byte selects to the shared bus.
- `s_data_s`, in, DataWidth: read data from the shared bus.
- `s_ack`, `s_stall`, `s_err`, in, 1: responses from the shared bus.

## Operation
- State machine, 2 states: `IDLE`, `BUSY`. Registered `grant` index (width `$clog2(Count)`) and registered `last` index.
- Reset: state `IDLE`, `grant`=0, `last`=Count-1.
- Reset output values:
  - `s_cyc`/`s_stb`/`s_we`=0.
  - `s_addr`/`s_data_m`/`s_sel`=0.
  - `m_stall`=all 1.
  - `m_ack`/`m_err`=0.
  - `m_data_s`=0.
- `IDLE`:
  - All `s_*` outputs 0; every master sees `stall`=1, `ack`=0, `err`=0.
  - If any `m_cyc` is high: pick the first requester searching upward from `last`+1 with wrap-around. Load `grant` and `last` with it. Go to `BUSY`.
- `BUSY`:
  - `s_cyc`, `s_stb`, `s_we`, `s_addr`, `s_data_m` and `s_sel` are combinational copies of master[`grant`].
  - Master[`grant`] receives `s_stall`, `s_ack`, `s_err` and `s_data_s` combinationally.
  - Every other master sees `stall`=1, `ack`=0, `err`=0.
  - `m_data_s` to non-granted masters is 0.
  - When `m_cyc[grant]`=0, `s_cyc` is low that same cycle; go to `IDLE`.
- Grant changes only in `IDLE`, so a master is never preempted mid-cycle.
- Responses (`s_ack`/`s_err`) that arrive in `IDLE` are dropped.
- A master that drops `cyc` while it is not granted is simply skipped.
- Simultaneous requests: round-robin from `last`+1. Two masters each holding `cyc` permanently alternate grants.
- Reset during `BUSY`: immediate return to `IDLE`, with all outputs at their reset values on the next cycle.

## Timing
- Grant latency: `m_cyc` rising in cycle N gives `s_cyc`=1 in cycle N+1 at the earliest.
- Master-to-slave and slave-to-master paths in `BUSY` are combinational: zero added latency, full pipelined throughput.
- Handover: `m_cyc[grant]` falls in cycle N, so the state is `IDLE` in N+1 and the next master's `s_cyc` rises in N+2. Minimum gap between bus cycles is one idle cycle.
- No combinational path from `m_cyc` to `m_stall` in `IDLE`; stall is constant 1 there.

## Configuration
- Macro: `WB_ARBITER_TIMEOUT_EN`.
- Defined:
  - An 8+ bit counter clears on entering `BUSY`, on any `s_ack`/`s_err`, and on any accepted strobe (`s_stb`&&!`s_stall`). It increments on every other `BUSY` cycle.
  - When it reaches `TimeoutCycles`, the arbiter asserts `m_err[grant]` for exactly one cycle and forces `s_cyc`=0 that cycle, which aborts the slave.
  - State then goes to `IDLE` and `last`=`grant`, so the next search starts after the timed-out master.
  - The master must still drop `cyc` before it is granted again.
- Not defined:
  - No counter is built; `BUSY` is held until the master releases `cyc`.

## Structure
- Package `wb_pkg`: `DataWidth`/`AddrWidth` defaults, `SelWidth`, and the `arb_state_t` enum (`IDLE`, `BUSY`). It is shared with `wb_multiplexer`.
- Sub-module `wb_rr_pick`: purely combinational round-robin picker.
  - Inputs: `req[Count]`, `last`.
  - Outputs: `valid`, `index`.
- `wb_arbiter` holds the state machine, the grant registers, the muxing and the optional watchdog.

## Test plan
- Single request: master 1 raises `cyc`/`stb`, read of address 0x20000000; slave acks with 0xA5. Expect `s_cyc` in the next cycle, `m_data_s[1]`=0xA5 with `m_ack[1]`, and `m_stall[0]`=1 throughout.
- Simultaneous request: masters 0 and 1 raise `cyc` in the same cycle after reset. Expect master 0 granted first; when it releases, master 1's `s_cyc` rises exactly 2 cycles later.
- Fairness: both masters hold `cyc` and release after each ack. Expect the grant sequence 0,1,0,1 over 4 bus cycles with no starvation.
- Pipelined burst: master 0 issues 4 strobes while the slave stalls on the 2nd. Expect 4 `s_stb` accepts, 4 acks routed to master 0 only, and no ack on master 1.
- Reset mid-operation: assert `reset` during `BUSY`. Next cycle expect `s_cyc`=0, all `m_stall`=1, and master 0 granted first afterwards.
- Timeout (`WB_ARBITER_TIMEOUT_EN`, `TimeoutCycles`=8): the slave never acks. Expect a one-cycle `m_err[grant]` pulse and `s_cyc`=0 after 8 stalled cycles, then a grant to the other requester.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the arbiter and the address multiplexer.
package wb_pkg;

    localparam int DefDataWidth = 32;
    localparam int DefAddrWidth = 32;
    localparam int SelWidth     = DefDataWidth / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // One byte-select line per data byte.
    function automatic int sel_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from last+1 with wrap-around.
module wb_rr_pick #(
    parameter int Count = 2,
    parameter int IdxW  = $clog2(Count)
) (
    input  logic [Count-1:0] req,
    input  logic [IdxW-1:0]  last,
    output logic             valid,
    output logic [IdxW-1:0]  index
);

    logic [IdxW-1:0] w_cand;

    // Walk the candidates in priority order; the first hit wins.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        w_cand = '0;
        for (int k = 1; k <= Count; k++) begin
            w_cand = IdxW'((int'(last) + k) % Count);
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                index = w_cand;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone port among Count masters.
// Optional bus watchdog enabled with `define WB_ARBITER_TIMEOUT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int  Count         = 2,
    parameter int  DataWidth     = DefDataWidth,
    parameter int  AddrWidth     = DefAddrWidth,
    parameter int  TimeoutCycles = 255,
    localparam int SelW          = sel_width(DataWidth)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [Count-1:0]                m_cyc,
    input  logic [Count-1:0]                m_stb,
    input  logic [Count-1:0]                m_we,
    input  logic [Count-1:0][AddrWidth-1:0] m_addr,
    input  logic [Count-1:0][DataWidth-1:0] m_data_m,
    input  logic [Count-1:0][SelW-1:0]      m_sel,
    output logic [Count-1:0][DataWidth-1:0] m_data_s,
    output logic [Count-1:0]                m_ack,
    output logic [Count-1:0]                m_stall,
    output logic [Count-1:0]                m_err,
    output logic                            s_cyc,
    output logic                            s_stb,
    output logic                            s_we,
    output logic [AddrWidth-1:0]            s_addr,
    output logic [DataWidth-1:0]            s_data_m,
    output logic [SelW-1:0]                 s_sel,
    input  logic [DataWidth-1:0]            s_data_s,
    input  logic                            s_ack,
    input  logic                            s_stall,
    input  logic                            s_err
);

    localparam int IdxW = $clog2(Count);

    if (Count < 2) begin : g_bad_count
        $error("wb_arbiter: Count must be at least 2");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("wb_arbiter: TimeoutCycles must be at least 1");
    end

    arb_state_t      r_state;
    logic [IdxW-1:0] r_grant;
    logic [IdxW-1:0] r_last;

    logic [Count-1:0] w_req;
    logic             w_pick_valid;
    logic [IdxW-1:0]  w_pick_index;
    logic             w_timeout;

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CntW = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);

    logic [CntW-1:0]  r_wdog;
    logic [Count-1:0] r_blocked;
    logic             w_activity;

    assign w_activity = s_ack | s_err | (s_stb & ~s_stall);
    assign w_timeout  = (r_state == BUSY) && (r_wdog == CntLimit);
    // A timed-out master stays out of arbitration until it drops cyc.
    assign w_req      = m_cyc & ~r_blocked;

    // Watchdog: counts BUSY cycles with no ack, error or accepted strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (r_state != BUSY) begin
            r_wdog <= '0;
        end else if (w_activity) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + CntW'(1);
        end
    end

    // Block flags for masters whose bus cycle was aborted by the watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blocked <= '0;
        end else begin
            for (int i = 0; i < Count; i++) begin
                if (!m_cyc[i]) begin
                    r_blocked[i] <= 1'b0;
                end else if (w_timeout && (r_grant == IdxW'(i))) begin
                    r_blocked[i] <= 1'b1;
                end
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_req     = m_cyc;
`endif

    wb_rr_pick #(
        .Count (Count),
        .IdxW  (IdxW)
    ) u_pick (
        .req   (w_req),
        .last  (r_last),
        .valid (w_pick_valid),
        .index (w_pick_index)
    );

    // Arbitration state; the grant only moves in IDLE so a cycle is never preempted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IdxW'(Count - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= BUSY;
                        r_grant <= w_pick_index;
                        r_last  <= w_pick_index;
                    end
                end
                BUSY: begin
                    if (w_timeout || !m_cyc[r_grant]) begin
                        r_state <= IDLE;
                        r_last  <= r_grant;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Bus muxing: in BUSY the granted master and the slave see each other directly.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_data_m = '0;
        s_sel    = '0;
        m_stall  = '1;
        m_ack    = '0;
        m_err    = '0;
        m_data_s = '0;
        if (r_state == BUSY) begin
            s_cyc             = m_cyc[r_grant] & ~w_timeout;
            s_stb             = m_stb[r_grant];
            s_we              = m_we[r_grant];
            s_addr            = m_addr[r_grant];
            s_data_m          = m_data_m[r_grant];
            s_sel             = m_sel[r_grant];
            m_stall[r_grant]  = s_stall;
            m_ack[r_grant]    = s_ack;
            m_err[r_grant]    = s_err | w_timeout;
            m_data_s[r_grant] = s_data_s;
        end else begin
            s_cyc = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// run against a rule-level arbitration model.
`timescale 1ns/1ps
module tb_wb_arbiter;

    localparam int N = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       m_cyc, m_stb, m_we;
    logic [N-1:0][31:0] m_addr, m_data_m;
    logic [N-1:0][3:0]  m_sel;
    logic [N-1:0][31:0] m_data_s;
    logic [N-1:0]       m_ack, m_stall, m_err;
    logic               s_cyc, s_stb, s_we;
    logic [31:0]        s_addr, s_data_m;
    logic [3:0]         s_sel;
    logic [31:0]        s_data_s;
    logic               s_ack, s_stall, s_err;

    int checks = 0;
    int failures = 0;

    // Reference-model state for the randomized run.
    bit           md_busy;
    logic [1:0]   md_owner;
    logic [1:0]   md_last;
    logic [N-1:0] md_blk;
    int           md_idle;

    wb_arbiter #(
        .Count         (N),
        .DataWidth     (32),
        .AddrWidth     (32),
        .TimeoutCycles (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_cyc    (m_cyc),
        .m_stb    (m_stb),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_data_m (m_data_m),
        .m_sel    (m_sel),
        .m_data_s (m_data_s),
        .m_ack    (m_ack),
        .m_stall  (m_stall),
        .m_err    (m_err),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_data_m (s_data_m),
        .s_sel    (s_sel),
        .s_data_s (s_data_s),
        .s_ack    (s_ack),
        .s_stall  (s_stall),
        .s_err    (s_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_addr = '0; m_data_m = '0; m_sel = '0;
        s_data_s = '0; s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Round robin from the rules: first requester after 'after', wrapping.
    function automatic int rr_model(input logic [N-1:0] req, input int after);
        logic [1:0] j;
        for (int k = 1; k <= N; k++) begin
            j = 2'((after + k) % N);
            if (req[j]) return int'(j);
        end
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({s_cyc, s_stb, s_we, s_addr, s_data_m, s_sel} !== 71'd0) begin
            failures++;
            $display("FAIL reset_s_outputs: got %h expected 0", {s_cyc, s_stb, s_we, s_addr, s_data_m, s_sel});
        end
        checks++;
        if ({m_stall, m_ack, m_err} !== {3'b111, 3'b000, 3'b000}) begin
            failures++;
            $display("FAIL reset_m_flags: got stall=%b ack=%b err=%b expected 111/000/000", m_stall, m_ack, m_err);
        end
        checks++;
        if (m_data_s !== 96'd0) begin
            failures++;
            $display("FAIL reset_m_data: got %h expected 0", m_data_s);
        end
        // Requests and slave responses in IDLE must not leak through.
        m_cyc = 3'b111; m_stb = 3'b111; s_ack = 1'b1; s_err = 1'b1; s_stall = 1'b0;
        s_data_s = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({s_cyc, m_stall, m_ack, m_err, m_data_s} !== {1'b0, 3'b111, 3'b000, 3'b000, 96'd0}) begin
            failures++;
            $display("FAIL idle_isolation: got cyc=%b stall=%b ack=%b err=%b expected 0/111/000/000",
                     s_cyc, m_stall, m_ack, m_err);
        end
        clear_inputs();
    endtask

    task automatic test_single_request();
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_addr[1] = 32'h2000_0000; m_sel[1] = 4'hF;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: s_cyc got %b expected 0 in request cycle", s_cyc);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({s_cyc, s_stb, s_we, s_addr, m_stall[0], m_stall[1]} !== {1'b1, 1'b1, 1'b0, 32'h2000_0000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_grant: got cyc=%b stb=%b we=%b addr=%h stall=%b expected 1/1/0/20000000/x01",
                     s_cyc, s_stb, s_we, s_addr, m_stall);
        end
        next_cycle();
        m_stb[1] = 1'b0; s_ack = 1'b1; s_data_s = 32'h0000_00A5;
        @(negedge clk);
        checks++;
        if ({m_ack[1], m_data_s[1], m_ack[0], m_data_s[0], m_stall[0]} !== {1'b1, 32'h0000_00A5, 1'b0, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_ack: got ack=%b d1=%h d0=%h stall0=%b expected ack=010 d1=a5 d0=0 stall0=1",
                     m_ack, m_data_s[1], m_data_s[0], m_stall[0]);
        end
        next_cycle();
        m_cyc[1] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0) begin
            failures++;
            $display("FAIL single_release: s_cyc got %b expected 0 same cycle", s_cyc);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        m_cyc = 3'b011; m_stb = 3'b011;
        m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0200;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({s_cyc, s_addr, m_stall[1]} !== {1'b1, 32'h0000_0100, 1'b1}) begin
            failures++;
            $display("FAIL simul_first: got cyc=%b addr=%h stall1=%b expected 1/00000100/1", s_cyc, s_addr, m_stall[1]);
        end
        next_cycle();
        m_cyc[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0) begin
            failures++;
            $display("FAIL simul_drop: s_cyc got %b expected 0", s_cyc);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0) begin
            failures++;
            $display("FAIL simul_gap: s_cyc got %b expected 0 in idle gap", s_cyc);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({s_cyc, s_addr} !== {1'b1, 32'h0000_0200}) begin
            failures++;
            $display("FAIL simul_handover: got cyc=%b addr=%h expected 1/00000200", s_cyc, s_addr);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_fairness();
        bit found;
        int owner;
        do_reset();
        m_cyc = 3'b011; m_stb = 3'b011;
        m_addr[0] = 32'hA000_0000; m_addr[1] = 32'hB000_0000;
        for (int bus = 0; bus < 4; bus++) begin
            found = 1'b0;
            for (int t = 0; t < 8 && !found; t++) begin
                @(negedge clk);
                if (s_cyc) found = 1'b1;
                else next_cycle();
            end
            owner = (s_addr == 32'hA000_0000) ? 0 : ((s_addr == 32'hB000_0000) ? 1 : -1);
            checks++;
            if (!found || owner != (bus % 2) || m_stall[1 - (bus % 2)] !== 1'b1) begin
                failures++;
                $display("FAIL fairness_bus%0d: got found=%0d owner=%0d stall=%b expected owner %0d",
                         bus, found, owner, m_stall, bus % 2);
            end
            if (!found || owner < 0) owner = bus % 2;
            s_ack = 1'b1;
            next_cycle();
            s_ack = 1'b0;
            m_cyc[owner] = 1'b0;
            next_cycle();
            m_cyc[owner] = 1'b1;
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int sent, acks0, acks1, pend;
        bit stalled, stall_leak;
        do_reset();
        m_cyc = 3'b011; m_stb[1] = 1'b1;
        m_addr[0] = 32'h0000_0300; m_addr[1] = 32'h0000_0400;
        sent = 0; acks0 = 0; acks1 = 0; pend = 0; stalled = 1'b0; stall_leak = 1'b0;
        for (int t = 0; t < 24 && acks0 < 4; t++) begin
            m_stb[0] = (sent < 4);
            s_stall = (sent == 1) && !stalled;
            if (s_stall) stalled = 1'b1;
            s_ack = (pend != 0);
            s_data_s = 32'(t);
            @(negedge clk);
            if (m_ack[0]) acks0++;
            if (m_ack[1]) acks1++;
            if (m_stall[1] !== 1'b1) stall_leak = 1'b1;
            if (s_cyc && s_stb && !s_stall) begin
                sent++;
                pend = 1;
            end else begin
                pend = 0;
            end
            next_cycle();
        end
        checks++;
        if (sent != 4 || acks0 != 4 || !stalled) begin
            failures++;
            $display("FAIL burst_counts: got accepts=%0d acks0=%0d stalled=%0d expected 4/4/1", sent, acks0, stalled);
        end
        checks++;
        if (acks1 != 0 || stall_leak) begin
            failures++;
            $display("FAIL burst_isolation: got acks1=%0d stall_leak=%0d expected 0/0", acks1, stall_leak);
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc = 3'b010; m_stb = 3'b011;
        m_addr[0] = 32'h0000_0500; m_addr[1] = 32'h0000_0600;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({s_cyc, s_addr} !== {1'b1, 32'h0000_0600}) begin
            failures++;
            $display("FAIL rstmid_busy: got cyc=%b addr=%h expected 1/00000600", s_cyc, s_addr);
        end
        next_cycle();
        m_cyc = 3'b011;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_cyc, m_stall, m_ack, m_err} !== {1'b0, 3'b111, 3'b000, 3'b000}) begin
            failures++;
            $display("FAIL rstmid_idle: got cyc=%b stall=%b ack=%b err=%b expected 0/111/000/000",
                     s_cyc, m_stall, m_ack, m_err);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({s_cyc, s_addr} !== {1'b1, 32'h0000_0500}) begin
            failures++;
            $display("FAIL rstmid_regrant: got cyc=%b addr=%h expected 1/00000500", s_cyc, s_addr);
        end
        clear_inputs();
        next_cycle();
    endtask

`ifdef WB_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        bit early_bad;
        do_reset();
        m_cyc = 3'b011; m_stb = 3'b011; s_stall = 1'b1;
        m_addr[0] = 32'h0000_0700; m_addr[1] = 32'h0000_0800;
        early_bad = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            next_cycle();
            @(negedge clk);
            if (i < 9) begin
                if (s_cyc !== 1'b1 || m_err !== 3'b000) early_bad = 1'b1;
            end else begin
                checks++;
                if ({s_cyc, m_err} !== {1'b0, 3'b001} || early_bad) begin
                    failures++;
                    $display("FAIL timeout_pulse: got cyc=%b err=%b early_bad=%0d expected 0/001/0",
                             s_cyc, m_err, early_bad);
                end
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({s_cyc, m_err} !== {1'b0, 3'b000}) begin
            failures++;
            $display("FAIL timeout_one_cycle: got cyc=%b err=%b expected 0/000", s_cyc, m_err);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({s_cyc, s_addr} !== {1'b1, 32'h0000_0800}) begin
            failures++;
            $display("FAIL timeout_next_grant: got cyc=%b addr=%h expected 1/00000800", s_cyc, s_addr);
        end
        m_cyc[1] = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0) begin
            failures++;
            $display("FAIL timeout_blocked: s_cyc got %b expected 0 while aborted master holds cyc", s_cyc);
        end
        m_cyc[0] = 1'b0;
        next_cycle();
        m_cyc[0] = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({s_cyc, s_addr} !== {1'b1, 32'h0000_0700}) begin
            failures++;
            $display("FAIL timeout_rearm: got cyc=%b addr=%h expected 1/00000700", s_cyc, s_addr);
        end
        clear_inputs();
        next_cycle();
    endtask
`endif

    task automatic test_random(input int ncyc);
        logic [70:0]        exp_s, got_s;
        logic [N-1:0]       exp_stall, exp_ack, exp_err;
        logic [N-1:0][31:0] exp_data;
        logic               to, quiet;
        int                 w;
        do_reset();
        md_busy = 1'b0; md_owner = 2'd0; md_last = 2'(N - 1); md_blk = '0; md_idle = 0;
        for (int c = 0; c < ncyc; c++) begin
            quiet = ((c / 40) % 2) == 1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = 1'($urandom_range(1));
                m_we[i] = 1'($urandom_range(1));
                m_addr[i] = $urandom;
                m_data_m[i] = $urandom;
                m_sel[i] = 4'($urandom);
            end
            s_ack = quiet ? 1'b0 : ($urandom_range(2) == 0);
            s_stall = quiet ? 1'b1 : ($urandom_range(2) == 0);
            s_err = quiet ? 1'b0 : ($urandom_range(15) == 0);
            s_data_s = $urandom;
            @(negedge clk);
`ifdef WB_ARBITER_TIMEOUT_EN
            to = md_busy && (md_idle == 8);
`else
            to = 1'b0;
`endif
            exp_s = '0; exp_stall = '1; exp_ack = '0; exp_err = '0; exp_data = '0;
            if (md_busy) begin
                exp_s = {m_cyc[md_owner] & ~to, m_stb[md_owner], m_we[md_owner],
                         m_addr[md_owner], m_data_m[md_owner], m_sel[md_owner]};
                exp_stall[md_owner] = s_stall;
                exp_ack[md_owner] = s_ack;
                exp_err[md_owner] = s_err | to;
                exp_data[md_owner] = s_data_s;
            end
            got_s = {s_cyc, s_stb, s_we, s_addr, s_data_m, s_sel};
            checks++;
            if (got_s !== exp_s) begin
                failures++;
                $display("FAIL random_slave_side cycle=%0d: got %h expected %h", c, got_s, exp_s);
            end
            checks++;
            if ({m_stall, m_ack, m_err, m_data_s} !== {exp_stall, exp_ack, exp_err, exp_data}) begin
                failures++;
                $display("FAIL random_master_side cycle=%0d: got %h expected %h", c,
                         {m_stall, m_ack, m_err, m_data_s}, {exp_stall, exp_ack, exp_err, exp_data});
            end
            if (!md_busy) begin
                w = rr_model(m_cyc & ~md_blk, int'(md_last));
                if (w >= 0) begin
                    md_busy = 1'b1; md_owner = 2'(w); md_last = 2'(w); md_idle = 0;
                end
            end else if (to) begin
                md_blk[md_owner] = 1'b1;
                md_busy = 1'b0;
            end else if (!m_cyc[md_owner]) begin
                md_busy = 1'b0;
            end else if (s_ack || s_err || (m_stb[md_owner] && !s_stall)) begin
                md_idle = 0;
            end else begin
                md_idle++;
            end
            md_blk = md_blk & m_cyc;
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_request();
        test_simultaneous();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        test_random(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
